// File: rtl/dds_sample_gen.sv
// DDS sample source: a divided sample tick steps a phase accumulator whose phase is
// mapped to sine/square/triangle/sawtooth, amplitude-scaled and strobed out.
module dds_sample_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter int PHASE_WIDTH = 24,
  parameter int SAMPLE_DIV  = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PHASE_WIDTH-1:0] cfg_ftw,
  input  logic [1:0]             cfg_wave,
  input  logic [DATA_WIDTH:0]    cfg_amp,
  input  logic                   cfg_phase_rst,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   data_valid
);
  localparam int DW    = DATA_WIDTH;
  localparam int PW    = PHASE_WIDTH;
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DW:0]      AMP_UNITY = {1'b1, {DW{1'b0}}};

  typedef enum logic [1:0] {
    WAVE_SINE     = 2'd0,
    WAVE_SQUARE   = 2'd1,
    WAVE_TRIANGLE = 2'd2,
    WAVE_SAW      = 2'd3
  } wave_e;

  // First quadrant of round(127*sin(2*pi*k/256)), k = 0..64.
  function automatic logic [6:0] sine_quarter(input logic [6:0] k);
    logic [6:0] s;
    case (k)
      7'd0:  s = 7'd0;   7'd1:  s = 7'd3;   7'd2:  s = 7'd6;   7'd3:  s = 7'd9;
      7'd4:  s = 7'd12;  7'd5:  s = 7'd16;  7'd6:  s = 7'd19;  7'd7:  s = 7'd22;
      7'd8:  s = 7'd25;  7'd9:  s = 7'd28;  7'd10: s = 7'd31;  7'd11: s = 7'd34;
      7'd12: s = 7'd37;  7'd13: s = 7'd40;  7'd14: s = 7'd43;  7'd15: s = 7'd46;
      7'd16: s = 7'd49;  7'd17: s = 7'd51;  7'd18: s = 7'd54;  7'd19: s = 7'd57;
      7'd20: s = 7'd60;  7'd21: s = 7'd63;  7'd22: s = 7'd65;  7'd23: s = 7'd68;
      7'd24: s = 7'd71;  7'd25: s = 7'd73;  7'd26: s = 7'd76;  7'd27: s = 7'd78;
      7'd28: s = 7'd81;  7'd29: s = 7'd83;  7'd30: s = 7'd85;  7'd31: s = 7'd88;
      7'd32: s = 7'd90;  7'd33: s = 7'd92;  7'd34: s = 7'd94;  7'd35: s = 7'd96;
      7'd36: s = 7'd98;  7'd37: s = 7'd100; 7'd38: s = 7'd102; 7'd39: s = 7'd104;
      7'd40: s = 7'd106; 7'd41: s = 7'd107; 7'd42: s = 7'd109; 7'd43: s = 7'd111;
      7'd44: s = 7'd112; 7'd45: s = 7'd113; 7'd46: s = 7'd115; 7'd47: s = 7'd116;
      7'd48: s = 7'd117; 7'd49: s = 7'd118; 7'd50: s = 7'd120; 7'd51: s = 7'd121;
      7'd52: s = 7'd122; 7'd53: s = 7'd122; 7'd54: s = 7'd123; 7'd55: s = 7'd124;
      7'd56: s = 7'd125; 7'd57: s = 7'd125; 7'd58: s = 7'd126; 7'd59: s = 7'd126;
      7'd60: s = 7'd126; 7'd61: s = 7'd127; 7'd62: s = 7'd127; 7'd63: s = 7'd127;
      default: s = 7'd127;
    endcase
    return s;
  endfunction

  function automatic logic [DW-1:0] wave_map(input logic [PW-1:0] phase, input wave_e wave);
    logic [DW-1:0] p;
    logic [DW-1:0] t;
    logic [7:0]    q;
    logic [7:0]    s8;
    logic [6:0]    fwd;
    logic [6:0]    mirror;
    p      = DW'(phase >> (PW - DW));
    q      = 8'(phase >> (PW - 8));
    fwd    = {1'b0, q[5:0]};
    mirror = 7'd64 - fwd;
    t      = p << 1;
    case (q[7:6])
      2'd0:    s8 = 8'd128 + {1'b0, sine_quarter(fwd)};
      2'd1:    s8 = 8'd128 + {1'b0, sine_quarter(mirror)};
      2'd2:    s8 = 8'd128 - {1'b0, sine_quarter(fwd)};
      default: s8 = 8'd128 - {1'b0, sine_quarter(mirror)};
    endcase
    case (wave)
      WAVE_SINE:     return DW'(s8) << (DW - 8);
      WAVE_SQUARE:   return p[DW-1] ? '0 : '1;
      WAVE_TRIANGLE: return p[DW-1] ? ~t : t;
      default:       return p;
    endcase
  endfunction

  logic             run_q;
  logic [DIV_W-1:0] div_cnt;
  logic [PW-1:0]    phase_acc;
  logic [PW-1:0]    act_ftw;
  wave_e            act_wave;
  logic [DW:0]      act_amp;
  logic             pending;
  logic [PW-1:0]    sh_ftw;
  wave_e            sh_wave;
  logic [DW:0]      sh_amp;
  logic             sh_prst;
  logic             stage1_valid;
  logic [DW-1:0]    raw_q;
  logic [DW:0]      amp_q;

  logic             tick;
  logic             commit;
  logic             restart;
  logic             cfg_accept;
  logic [PW-1:0]    sel_ftw;
  wave_e            sel_wave;
  logic [DW:0]      sel_amp;
  logic [PW-1:0]    sample_phase;
  logic [PW-1:0]    acc_next;
  logic [DW-1:0]    raw_next;
  logic [2*DW:0]    product;

  assign cfg_ready = ~pending;

  // NOTE: every signal here is assigned on every path, so no latch is inferred.
  always_comb begin
    tick         = enable && run_q && (div_cnt == DIV_LAST);
    commit       = tick && pending;
    restart      = commit && sh_prst;
    cfg_accept   = cfg_valid && !pending;
    sel_ftw      = commit ? sh_ftw  : act_ftw;
    sel_wave     = commit ? sh_wave : act_wave;
    sel_amp      = commit ? sh_amp  : act_amp;
    sample_phase = restart ? '0 : phase_acc;
    acc_next     = restart ? sh_ftw : phase_acc + sel_ftw;
    raw_next     = wave_map(sample_phase, sel_wave);
    product      = (2*DW+1)'(raw_q) * (2*DW+1)'(amp_q);
  end

  // NOTE: state is updated with non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q        <= 1'b0;
      div_cnt      <= '0;
      phase_acc    <= '0;
      act_ftw      <= '0;
      act_wave     <= WAVE_SINE;
      act_amp      <= '0;
      pending      <= 1'b0;
      sh_ftw       <= '0;
      sh_wave      <= WAVE_SINE;
      sh_amp       <= '0;
      sh_prst      <= 1'b0;
      stage1_valid <= 1'b0;
      raw_q        <= '0;
      amp_q        <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
    end else begin
      // Registered enable places the first tick SAMPLE_DIV cycles after enable rises.
      run_q <= enable;
      if (!enable || !run_q || div_cnt == DIV_LAST) div_cnt <= '0;
      else                                          div_cnt <= div_cnt + DIV_W'(1);

      if (tick) begin
        phase_acc <= acc_next;
        act_ftw   <= sel_ftw;
        act_wave  <= sel_wave;
        act_amp   <= sel_amp;
      end

      if (cfg_accept) begin
        pending <= 1'b1;
        sh_ftw  <= cfg_ftw;
        sh_wave <= wave_e'(cfg_wave);
        sh_amp  <= (cfg_amp > AMP_UNITY) ? AMP_UNITY : cfg_amp;
        sh_prst <= cfg_phase_rst;
      end else if (commit) begin
        pending <= 1'b0;
      end

      stage1_valid <= tick;
      if (tick) begin
        raw_q <= raw_next;
        amp_q <= sel_amp;
      end

      data_valid <= stage1_valid;
      if (stage1_valid) data_out <= DW'(product >> DW);
    end
  end

endmodule

// File: tb/tb_dds_sample_gen.sv
// Self-checking bench for dds_sample_gen: directed and random configurations
// compared against a sample-level reference model built from real-valued sine.
module tb_dds_sample_gen;
  localparam int  DW  = 8;
  localparam int  PW  = 24;
  localparam int  DIV = 256;
  localparam real PI  = 3.14159265358979;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [PW-1:0] cfg_ftw;
  logic [1:0]    cfg_wave;
  logic [DW:0]   cfg_amp;
  logic          cfg_phase_rst;
  logic [DW-1:0] data_out;
  logic          data_valid;

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  int unsigned last_strobe = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dds_sample_gen #(.DATA_WIDTH(DW), .PHASE_WIDTH(PW), .SAMPLE_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ftw(cfg_ftw),
    .cfg_wave(cfg_wave), .cfg_amp(cfg_amp), .cfg_phase_rst(cfg_phase_rst),
    .data_out(data_out), .data_valid(data_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: dut=%0d model=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (one call per sample) ----------------
  typedef struct {
    int ftw;
    int wave;
    int amp;
    bit prst;
  } cfg_t;

  cfg_t   active;
  cfg_t   shadow;
  bit     pend;
  longint acc;

  function automatic int sine_s(int k);
    if (k == 64) return 127;
    return $rtoi($floor(127.0 * $sin(2.0 * PI * k / 256.0) + 0.5));
  endfunction

  function automatic int model_value(longint phase, int wave, int amp);
    int full, half, p, q, quad, i, s, raw, a;
    full = 1 << DW;
    half = full / 2;
    p    = int'(phase >> (PW - DW));
    q    = int'(phase >> (PW - 8));
    quad = q / 64;
    i    = q % 64;
    case (wave)
      0: begin
        case (quad)
          0:       s = 128 + sine_s(i);
          1:       s = 128 + sine_s(64 - i);
          2:       s = 128 - sine_s(i);
          default: s = 128 - sine_s(64 - i);
        endcase
        raw = s * (full / 256);
      end
      1:       raw = (p < half) ? full - 1 : 0;
      2:       raw = (p < half) ? 2 * p : (full - 1) - ((2 * p) % full);
      default: raw = p;
    endcase
    a = (amp > full) ? full : amp;
    return (raw * a) / full;
  endfunction

  task automatic model_reset();
    active = '{ftw: 0, wave: 0, amp: 0, prst: 1'b0};
    shadow = active;
    pend   = 1'b0;
    acc    = 0;
  endtask

  task automatic model_offer(input int ftw, input int wave, input int amp, input bit prst);
    shadow = '{ftw: ftw, wave: wave, amp: amp, prst: prst};
    pend   = 1'b1;
  endtask

  task automatic model_tick(output int expv);
    longint ph;
    bit     restart;
    restart = 1'b0;
    if (pend) begin
      active  = shadow;
      restart = shadow.prst;
      pend    = 1'b0;
    end
    if (restart) begin
      ph  = 0;
      acc = active.ftw;
    end else begin
      ph  = acc;
      acc = (acc + longint'(active.ftw)) % (longint'(1) << PW);
    end
    expv = model_value(ph, active.wave, active.amp);
  endtask

  // ---------------- stimulus / observation helpers ----------------
  task automatic wait_strobe(output logic [DW-1:0] val, output int unsigned gap);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!data_valid && n < 2000);
    check("strobe_seen", data_valid, 1'b1);
    val         = data_out;
    gap         = cyc - last_strobe;
    last_strobe = cyc;
  endtask

  task automatic sample_check(input string tag, input int exp_gap);
    logic [DW-1:0] v;
    int unsigned   gap;
    int            expv;
    wait_strobe(v, gap);
    model_tick(expv);
    check(tag, v, expv);
    if (exp_gap > 0) check({tag, "_gap"}, gap, exp_gap);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) sample_check(tag, DIV);
  endtask

  task automatic count_strobes(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (data_valid) n++;
    end
  endtask

  task automatic drive_cfg(input int ftw, input int wave, input int amp, input bit prst);
    cfg_ftw       = PW'(ftw);
    cfg_wave      = 2'(wave);
    cfg_amp       = (DW+1)'(amp);
    cfg_phase_rst = prst;
  endtask

  task automatic send_cfg(input int ftw, input int wave, input int amp, input bit prst);
    int n;
    n = 0;
    drive_cfg(ftw, wave, amp, prst);
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("cfg_accept_in_time", n < 600, 1'b1);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("cfg_ready_drop", cfg_ready, 1'b0);
    model_offer(ftw, wave, amp, prst);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    enable = 1'b0;
    cfg_valid = 1'b0;
    drive_cfg(0, 0, 0, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    rst = 1'b0;

    // Sawtooth, unity gain; config waits while disabled.
    send_cfg(32'h010000, 3, 256, 1'b1);
    count_strobes(20, n);
    check("idle_no_strobe", n, 0);
    check("pending_while_disabled", cfg_ready, 0);
    enable = 1'b1;
    last_strobe = cyc;
    sample_check("saw_first", DIV + 2);
    check("cfg_ready_return", cfg_ready, 1);
    run("saw", 11);
    send_cfg(32'h100000, 3, 256, 1'b0);
    run("saw_wrap", 18);

    // Sine over one full 64-sample period plus the repeat.
    send_cfg(32'h040000, 0, 256, 1'b1);
    run("sine", 65);

    // Triangle at half gain hitting p = 0, 127, 128, 255, then amp 300 clamps.
    send_cfg(32'h7F0000, 2, 128, 1'b1);
    run("tri", 1);
    send_cfg(32'h010000, 2, 128, 1'b0);
    run("tri", 1);
    send_cfg(32'h7F0000, 2, 128, 1'b0);
    run("tri", 2);
    send_cfg(32'h010000, 2, 300, 1'b0);
    run("tri_clamp", 3);

    // Handshake: A accepted, B held while not ready, B taken only after A commits.
    send_cfg(32'h030000, 3, 256, 1'b1);
    drive_cfg(32'h050000, 1, 200, 1'b0);
    cfg_valid = 1'b1;
    repeat (10) @(negedge clk);
    check("hs_b_blocked", cfg_ready, 0);
    sample_check("hs_a", DIV);
    check("hs_b_accepted", cfg_ready, 0);
    cfg_valid = 1'b0;
    model_offer(32'h050000, 1, 200, 1'b0);
    run("hs_b", 3);

    // Config accepted in the tick cycle waits for the following tick.
    repeat (254) @(negedge clk);
    drive_cfg(32'h080000, 3, 256, 1'b1);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("tick_accept", cfg_ready, 0);
    sample_check("tick_accept_old", DIV);
    model_offer(32'h080000, 3, 256, 1'b1);
    run("tick_accept_new", 2);

    // Enable drop one cycle after a tick: in-flight sample still strobes.
    repeat (255) @(negedge clk);
    enable = 1'b0;
    sample_check("endrop_inflight", DIV);
    count_strobes(600, n);
    check("endrop_quiet", n, 0);
    enable = 1'b1;
    last_strobe = cyc;
    sample_check("reenable_first", DIV + 2);
    run("reenable", 2);

    // Reset mid-operation with a sample in flight and a config pending.
    repeat (254) @(negedge clk);
    drive_cfg(32'h020000, 1, 256, 1'b1);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("pre_rst_pending", cfg_ready, 0);
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check("mid_rst_data_out", data_out, 0);
    check("mid_rst_data_valid", data_valid, 0);
    check("mid_rst_cfg_ready", cfg_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    count_strobes(300, n);
    check("no_stale_strobe", n, 0);
    enable = 1'b1;
    last_strobe = cyc;
    sample_check("post_rst_first", DIV + 2);

    // Random configurations.
    for (int r = 0; r < 8; r++) begin
      send_cfg(int'($urandom % (32'd1 << PW)), int'($urandom % 4),
               int'($urandom_range(0, 511)), 1'($urandom % 2));
      run("rand", 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
